// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte sources,
// each buffered by its own small FIFO and drained one byte per grant.
module uart_tx_arbiter #(
    parameter int unsigned FIFO_AW      = 2,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [7:0]         req0_data,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [7:0]         req1_data,
    input  logic               req1_valid,
    output logic               req1_ready,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_busy,
    output logic               grant_id,
    output logic [FIFO_AW:0]   fifo0_level,
    output logic [FIFO_AW:0]   fifo1_level,
    output logic [1:0]         overflow
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned LW    = FIFO_AW + 1;
    localparam int unsigned TW    = 4;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_e;

    state_e               state_q, state_d;
    logic [7:0]           mem_q [2][DEPTH];
    logic [7:0]           mem_d [2][DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q [2], wr_ptr_d [2];
    logic [FIFO_AW-1:0]   rd_ptr_q [2], rd_ptr_d [2];
    logic [LW-1:0]        level_q [2], level_d [2];
    logic [1:0]           ovf_q, ovf_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 grant_q, grant_d;
    logic                 last_q, last_d;
    logic [TW-1:0]        cnt_q, cnt_d;

    logic [7:0]           data_in [2];
    logic [1:0]           valid_in, ready, nonempty, push, pop;
    logic                 sel_c;
    logic                 tx_valid_c;

    assign data_in[0] = req0_data;
    assign data_in[1] = req1_data;
    assign valid_in   = {req1_valid, req0_valid};
    assign ready[0]   = (level_q[0] != LW'(DEPTH));
    assign ready[1]   = (level_q[1] != LW'(DEPTH));
    assign nonempty[0] = (level_q[0] != '0);
    assign nonempty[1] = (level_q[1] != '0);

    // Scheduler: grant, strobe once, then wait out the UART busy window
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        pop        = '0;
        sel_c      = 1'b0;
        tx_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (|nonempty) begin
                    sel_c     = (nonempty == 2'b11) ? ~last_q : nonempty[1];
                    grant_d   = sel_c;
                    last_d    = sel_c;
                    tx_data_d = mem_q[sel_c][rd_ptr_q[sel_c]];
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_valid_c   = 1'b1;
                    pop[grant_q] = 1'b1;
                    cnt_d        = '0;
                    state_d      = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-requester FIFO bookkeeping; full FIFOs refuse pushes regardless of pop
    always_comb begin
        mem_d = mem_q;
        push  = '0;
        ovf_d = ovf_q;
        for (int i = 0; i < 2; i++) begin
            push[i]     = valid_in[i] & ready[i];
            wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + FIFO_AW'(1) : wr_ptr_q[i];
            rd_ptr_d[i] = pop[i] ? rd_ptr_q[i] + FIFO_AW'(1) : rd_ptr_q[i];
            level_d[i]  = level_q[i];
            if (push[i] && !pop[i]) begin
                level_d[i] = level_q[i] + LW'(1);
            end else if (!push[i] && pop[i]) begin
                level_d[i] = level_q[i] - LW'(1);
            end
            if (push[i]) mem_d[i][wr_ptr_q[i]] = data_in[i];
            ovf_d[i] = ovf_q[i] | (valid_in[i] & ~ready[i]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            tx_data_q <= 8'h00;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            ovf_q     <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                level_q[i]  <= '0;
                for (int j = 0; j < int'(DEPTH); j++) mem_q[i][j] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            mem_q     <= mem_d;
        end
    end

    assign req0_ready  = ready[0];
    assign req1_ready  = ready[1];
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_c;
    assign grant_id    = grant_q;
    assign fifo0_level = level_q[0];
    assign fifo1_level = level_q[1];
    assign overflow    = ovf_q;

endmodule
